// File: rtl/adc_pkt_pkg.sv
// Shared types and widths for the ADC packetizer slice.
// The optional ramp source is enabled with ADC_PKT_TEST_PATTERN_EN (see adc_packetizer).
package adc_pkt_pkg;

    localparam int ADC_SAMPLE_W = 16;
    localparam int ADC_AXIS_W   = 2 * ADC_SAMPLE_W;
    localparam int ADC_SIZE_W   = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2,
        DONE    = 2'd3
    } pkt_state_e;

    typedef logic [ADC_SIZE_W-3:0] beat_cnt_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO; a pop frees a slot for a same-cycle push.
// rdata reads as zero while empty so the stream data bus idles at zero.
module sync_fifo_fwft #(
    parameter int  WIDTH = 32,
    parameter int  DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             push_acc_s;
    logic             pop_acc_s;

    assign empty      = (count_r == CW'(0));
    assign full       = (count_r == CW'(DEPTH));
    assign count      = count_r;
    assign pop_acc_s  = pop && !empty;
    assign push_acc_s = push && (!full || pop_acc_s);
    assign rdata      = empty ? {WIDTH{1'b0}} : mem_r[rd_ptr_r];

    // Storage write port
    always_ff @(posedge clk) begin
        if (push_acc_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= CW'(0);
        end else begin
            if (push_acc_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_acc_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_acc_s, pop_acc_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/adc_packetizer.sv
// Packs ADC sample pairs into 32-bit AXI-Stream beats for a DMA transfer of pkt_bytes bytes.
// Define ADC_PKT_TEST_PATTERN_EN to add test_mode, which swaps s_data for a per-packet ramp.
module adc_packetizer
    import adc_pkt_pkg::*;
#(
    parameter int SAMPLE_W   = ADC_SAMPLE_W,
    parameter int AXIS_W     = 2 * SAMPLE_W,
    parameter int FIFO_DEPTH = 16,
    parameter int SIZE_W     = ADC_SIZE_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                s_valid,
    input  logic [SAMPLE_W-1:0] s_data,
`ifdef ADC_PKT_TEST_PATTERN_EN
    input  logic                test_mode,
`endif
    input  logic                start,
    input  logic [SIZE_W-1:0]   pkt_bytes,
    output logic [AXIS_W-1:0]   m_axis_tdata,
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready,
    output logic                m_axis_tlast,
    output logic                busy,
    output logic                done,
    output logic                overflow
);

    localparam int CNT_W  = SIZE_W - 2;
    localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;

    pkt_state_e          state_r;
    pkt_state_e          state_next_s;
    logic [CNT_W-1:0]    beats_req_s;
    logic [CNT_W-1:0]    beats_total_r;
    logic [CNT_W-1:0]    words_written_r;
    logic [CNT_W-1:0]    out_idx_r;
    logic                half_r;
    logic [SAMPLE_W-1:0] low_r;
    logic [SAMPLE_W-1:0] sample_s;
    logic [AXIS_W-1:0]   word_s;
    logic                overflow_r;
    logic                done_r;
    logic                busy_r;
    logic                start_ok_s;
    logic                sample_ok_s;
    logic                word_ready_s;
    logic                last_word_s;
    logic                pop_s;
    logic                drop_s;
    logic                fifo_full_s;
    logic                fifo_empty_s;
    logic [FCNT_W-1:0]   fifo_count_s;
    logic [1:0]          pkt_bytes_unused_s;

    assign pkt_bytes_unused_s = pkt_bytes[1:0];
    assign beats_req_s  = pkt_bytes[SIZE_W-1:2];
    assign start_ok_s   = (state_r == IDLE) && start;
    assign sample_ok_s  = (state_r == CAPTURE) && s_valid;
    assign word_ready_s = sample_ok_s && half_r;
    assign word_s       = {sample_s, low_r};
    assign last_word_s  = (words_written_r == beats_total_r - CNT_W'(1));
    assign pop_s        = m_axis_tvalid && m_axis_tready;
    assign drop_s       = word_ready_s && fifo_full_s && !pop_s;

`ifdef ADC_PKT_TEST_PATTERN_EN
    logic [SAMPLE_W-1:0] ramp_r;

    // Ramp source restarts at zero with every accepted start
    always_ff @(posedge clk) begin
        if (reset) begin
            ramp_r <= {SAMPLE_W{1'b0}};
        end else if (start_ok_s) begin
            ramp_r <= {SAMPLE_W{1'b0}};
        end else if (sample_ok_s) begin
            ramp_r <= ramp_r + SAMPLE_W'(1);
        end
    end

    // Sample source select
    always_comb begin
        sample_s = s_data;
        if (test_mode) begin
            sample_s = ramp_r;
        end else begin
            sample_s = s_data;
        end
    end
`else
    assign sample_s = s_data;
`endif

    // Packet sequencing
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_ok_s && (beats_req_s != CNT_W'(0))) begin
                    state_next_s = CAPTURE;
                end else begin
                    state_next_s = IDLE;
                end
            end
            CAPTURE: begin
                if (word_ready_s && last_word_s) begin
                    state_next_s = DRAIN;
                end else begin
                    state_next_s = CAPTURE;
                end
            end
            DRAIN: begin
                if (fifo_empty_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = DRAIN;
                end
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Sample pairing, word/beat counters and sticky overflow
    always_ff @(posedge clk) begin
        if (reset) begin
            beats_total_r   <= CNT_W'(0);
            words_written_r <= CNT_W'(0);
            out_idx_r       <= CNT_W'(0);
            half_r          <= 1'b0;
            low_r           <= {SAMPLE_W{1'b0}};
            overflow_r      <= 1'b0;
        end else if (start_ok_s) begin
            beats_total_r   <= beats_req_s;
            words_written_r <= CNT_W'(0);
            out_idx_r       <= CNT_W'(0);
            half_r          <= 1'b0;
            overflow_r      <= 1'b0;
        end else begin
            if (sample_ok_s) begin
                half_r <= ~half_r;
                if (!half_r) begin
                    low_r <= sample_s;
                end
                if (half_r) begin
                    // dropped words still count so the packet length is honoured
                    words_written_r <= words_written_r + CNT_W'(1);
                end
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
            if (pop_s) begin
                out_idx_r <= out_idx_r + CNT_W'(1);
            end
        end
    end

    // Status outputs; a zero-length start yields done without leaving IDLE
    always_ff @(posedge clk) begin
        if (reset) begin
            done_r <= 1'b0;
            busy_r <= 1'b0;
        end else begin
            done_r <= (state_next_s == DONE) || (start_ok_s && (beats_req_s == CNT_W'(0)));
            busy_r <= (state_next_s != IDLE);
        end
    end

    sync_fifo_fwft #(
        .WIDTH (AXIS_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (word_ready_s),
        .wdata (word_s),
        .pop   (pop_s),
        .rdata (m_axis_tdata),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    // Once capture has ended, the sole remaining word is last even if words were dropped;
    // this term can only rise together with a new head word, so a stalled beat stays stable.
    assign m_axis_tvalid = !fifo_empty_s;
    assign m_axis_tlast  = m_axis_tvalid &&
                           ((out_idx_r == beats_total_r - CNT_W'(1)) ||
                            ((state_r == DRAIN) && (fifo_count_s == FCNT_W'(1))));
    assign done          = done_r;
    assign busy          = busy_r;
    assign overflow      = overflow_r;

endmodule

// File: tb/tb_adc_packetizer.sv
// Scoreboard bench for adc_packetizer: expected beats are queued as samples are driven
// and popped as the stream hands them off.
module tb_adc_packetizer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        s_valid = 1'b0;
    logic [15:0] s_data = 16'd0;
    logic        start = 1'b0;
    logic [31:0] pkt_bytes = 32'd0;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b0;
    logic        m_axis_tlast;
    logic        busy;
    logic        done;
    logic        overflow;
`ifdef ADC_PKT_TEST_PATTERN_EN
    logic        test_mode = 1'b0;
`endif

    int          check_cnt = 0;
    int          error_cnt = 0;
    int          beats_seen = 0;
    int          done_cnt = 0;
    logic [32:0] exp_q[$];
    logic [32:0] mon_e;
    logic        stall_prev = 1'b0;
    logic [31:0] held_data = 32'd0;
    logic        held_last = 1'b0;
    logic        abort = 1'b0;
    logic        stop_rand = 1'b0;
    int          b0;
    int          d0;

    adc_packetizer dut (
        .clk           (clk),
        .reset         (reset),
        .s_valid       (s_valid),
        .s_data        (s_data),
`ifdef ADC_PKT_TEST_PATTERN_EN
        .test_mode     (test_mode),
`endif
        .start         (start),
        .pkt_bytes     (pkt_bytes),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .busy          (busy),
        .done          (done),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        check_cnt++;
        if (act !== exp) begin
            error_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [31:0] bytes);
        pkt_bytes = bytes;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int dstart, input int budget);
        bit got;
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done_cnt > dstart) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check_val({"done_timeout_", tag}, 64'(got), 64'd1);
    endtask

    // Drive n sample pairs starting at base; the pair with index nbeats-1 is the last beat
    task automatic send_pairs(input int n, input logic [15:0] base, input int nbeats, input bit half_rate);
        logic [15:0] lo;
        logic [15:0] hi;
        logic        last;
        for (int i = 0; i < 2 * n; i++) begin
            s_valid = 1'b1;
            s_data  = 16'(base + 16'(i));
            if (i % 2 == 1) begin
                lo   = 16'(base + 16'(i - 1));
                hi   = 16'(base + 16'(i));
                last = ((i / 2) == nbeats - 1);
                exp_q.push_back({last, hi, lo});
            end
            tick();
            if (half_rate) begin
                s_valid = 1'b0;
                tick();
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_tvalid"}, 64'(m_axis_tvalid), 64'd0);
        check_val({tag, "_tlast"}, 64'(m_axis_tlast), 64'd0);
        check_val({tag, "_tdata"}, 64'(m_axis_tdata), 64'd0);
        check_val({tag, "_busy"}, 64'(busy), 64'd0);
        check_val({tag, "_done"}, 64'(done), 64'd0);
        check_val({tag, "_overflow"}, 64'(overflow), 64'd0);
    endtask

    // Stream monitor: stall stability, scoreboard compare, done pulse count
    always @(negedge clk) begin
        if (stall_prev) begin
            check_val("hold_tvalid", 64'(m_axis_tvalid), 64'd1);
            check_val("hold_tdata", 64'(m_axis_tdata), 64'(held_data));
            check_val("hold_tlast", 64'(m_axis_tlast), 64'(held_last));
        end
        if (m_axis_tvalid && m_axis_tready) begin
            beats_seen++;
            if (exp_q.size() == 0) begin
                check_val("sb_unexpected_beat", 64'(exp_q.size()), 64'd1);
            end else begin
                mon_e = exp_q.pop_front();
                check_val("tdata", 64'(m_axis_tdata), 64'(mon_e[31:0]));
                check_val("tlast", 64'(m_axis_tlast), 64'(mon_e[32]));
            end
        end
        if (done) begin
            done_cnt++;
        end
        stall_prev = m_axis_tvalid && !m_axis_tready;
        held_data  = m_axis_tdata;
        held_last  = m_axis_tlast;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        reset = 1'b1;
        tick();
        tick();
        check_idle_outputs("reset");
        reset = 1'b0;
        tick();

        // Full-rate packet, sink always ready
        m_axis_tready = 1'b1;
        d0 = done_cnt;
        b0 = beats_seen;
        pulse_start(32'd2048);
        send_pairs(512, 16'd0, 512, 1'b0);
        wait_done("t1", d0, 200);
        tick();
        check_val("t1_busy_after", 64'(busy), 64'd0);
        check_val("t1_done_once", 64'(done_cnt - d0), 64'd1);
        check_val("t1_beats", 64'(beats_seen - b0), 64'd512);
        check_val("t1_overflow", 64'(overflow), 64'd0);
        check_val("t1_sb_empty", 64'(exp_q.size()), 64'd0);

        // Same data with a randomly stalling sink
        d0 = done_cnt;
        b0 = beats_seen;
        stop_rand = 1'b0;
        pulse_start(32'd2048);
        fork
            begin
                send_pairs(512, 16'd0, 512, 1'b1);
                stop_rand = 1'b1;
            end
            begin
                while (!stop_rand) begin
                    m_axis_tready = 1'($urandom_range(0, 1));
                    tick();
                end
                m_axis_tready = 1'b1;
            end
        join
        wait_done("t2", d0, 400);
        tick();
        check_val("t2_busy_after", 64'(busy), 64'd0);
        check_val("t2_done_once", 64'(done_cnt - d0), 64'd1);
        check_val("t2_beats", 64'(beats_seen - b0), 64'd512);
        check_val("t2_overflow", 64'(overflow), 64'd0);
        check_val("t2_sb_empty", 64'(exp_q.size()), 64'd0);

        // Overflow: sink blocked for the first 40 pairs of a 64-beat packet
        m_axis_tready = 1'b0;
        d0 = done_cnt;
        b0 = beats_seen;
        pulse_start(32'd256);
        for (int w = 0; w < 64; w++) begin
            if (w < 16 || w >= 40) begin
                exp_q.push_back({(w == 63), 16'(2 * w + 1), 16'(2 * w)});
            end
            s_valid = 1'b1;
            s_data  = 16'(2 * w);
            tick();
            s_data  = 16'(2 * w + 1);
            tick();
            if (w == 15) begin
                check_val("t3_overflow_at16", 64'(overflow), 64'd0);
            end
            if (w == 16) begin
                check_val("t3_overflow_at17", 64'(overflow), 64'd1);
            end
            if (w == 39) begin
                m_axis_tready = 1'b1;
            end
        end
        s_valid = 1'b0;
        wait_done("t3", d0, 200);
        tick();
        check_val("t3_busy_after", 64'(busy), 64'd0);
        check_val("t3_done_once", 64'(done_cnt - d0), 64'd1);
        check_val("t3_beats", 64'(beats_seen - b0), 64'd40);
        check_val("t3_overflow_sticky", 64'(overflow), 64'd1);
        check_val("t3_sb_empty", 64'(exp_q.size()), 64'd0);

        // Zero-length packets (low two size bits are ignored)
        for (int k = 0; k < 2; k++) begin
            d0 = done_cnt;
            b0 = beats_seen;
            pulse_start((k == 0) ? 32'd0 : 32'd3);
            @(negedge clk);
            check_val("t4_done_pulse", 64'(done), 64'd1);
            check_val("t4_busy", 64'(busy), 64'd0);
            check_val("t4_overflow_cleared", 64'(overflow), 64'd0);
            @(negedge clk);
            check_val("t4_done_low", 64'(done), 64'd0);
            check_val("t4_busy_low", 64'(busy), 64'd0);
            repeat (5) tick();
            check_val("t4_no_beats", 64'(beats_seen - b0), 64'd0);
            check_val("t4_done_once", 64'(done_cnt - d0), 64'd1);
        end

        // A second start during capture must not change the packet
        d0 = done_cnt;
        b0 = beats_seen;
        pulse_start(32'd16);
        for (int i = 0; i < 16; i++) begin
            s_valid = 1'b1;
            s_data  = 16'(16'h0100 + i);
            if (i % 2 == 1 && i < 8) begin
                exp_q.push_back({(i == 7), 16'(16'h0100 + i), 16'(16'h0100 + i - 1)});
            end
            if (i == 3) begin
                start     = 1'b1;
                pkt_bytes = 32'd64;
            end
            tick();
            start = 1'b0;
        end
        s_valid = 1'b0;
        wait_done("t5", d0, 100);
        repeat (4) tick();
        check_val("t5_beats", 64'(beats_seen - b0), 64'd4);
        check_val("t5_done_once", 64'(done_cnt - d0), 64'd1);
        check_val("t5_busy_after", 64'(busy), 64'd0);
        check_val("t5_sb_empty", 64'(exp_q.size()), 64'd0);

        // Reset mid-packet, then a short packet
        m_axis_tready = 1'b1;
        b0 = beats_seen;
        abort = 1'b0;
        pulse_start(32'd2048);
        fork
            begin
                for (int i = 0; i < 1024; i++) begin
                    if (abort) begin
                        break;
                    end
                    s_valid = 1'b1;
                    s_data  = 16'(i);
                    if (i % 2 == 1) begin
                        exp_q.push_back({1'b0, 16'(i), 16'(i - 1)});
                    end
                    tick();
                end
                s_valid = 1'b0;
            end
            begin
                for (int j = 0; j < 1500; j++) begin
                    @(negedge clk);
                    if (beats_seen - b0 >= 100) begin
                        break;
                    end
                end
                check_val("t6_beat100_timeout", 64'(beats_seen - b0 >= 100), 64'd1);
                abort = 1'b1;
                @(posedge clk);
                #2;
                reset = 1'b1;
                tick();
                check_idle_outputs("t6_reset");
                reset = 1'b0;
                exp_q.delete();
            end
        join
        tick();
        d0 = done_cnt;
        b0 = beats_seen;
        pulse_start(32'd8);
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1;
            s_data  = 16'(16'hA000 + i);
            if (i % 2 == 1) begin
                exp_q.push_back({(i == 3), 16'(16'hA000 + i), 16'(16'hA000 + i - 1)});
            end
            tick();
        end
        s_valid = 1'b0;
        wait_done("t6", d0, 100);
        tick();
        check_val("t6_beats", 64'(beats_seen - b0), 64'd2);
        check_val("t6_done_once", 64'(done_cnt - d0), 64'd1);
        check_val("t6_busy_after", 64'(busy), 64'd0);

        check_val("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", check_cnt, error_cnt);
        $finish;
    end

endmodule
